// File: rtl/tx_chain.sv
// Buffered audio -> ramped gain -> FM modulator -> DUC -> 1-bit delta-sigma RF output.
// Define TX_CHAIN_STATS_EN to build the saturating underrun counter; otherwise it reads 0.
module tx_chain #(
    parameter int WIDTH      = 16,
    parameter int FCLK       = 200000000,
    parameter int FS_IN      = 48000,
    parameter int RATE_INT   = 100,
    parameter int FC         = 99000000,
    parameter int K          = 200000,
    parameter int IEXT       = 7,
    parameter int FIFO_DEPTH = 16,
    parameter int RAMP_LOG2  = 8,
    parameter int TONE_DIV   = 24
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [WIDTH-1:0]              data_in,
    input  logic                          valid_in,
    output logic                          ready_in,
    input  logic                          enable,
    input  logic [1:0]                    mode,
    output logic [WIDTH-1:0]              sample_out,
    output logic                          sample_stb,
    output logic [WIDTH-1:0]              data_int,
    output logic                          stb_int,
    output logic                          rf_out,
    output logic                          stb_out,
    output logic [1:0]                    state_o,
    output logic                          underrun,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   underrun_cnt
);
    localparam int TICK_DIV = FCLK / FS_IN;
    localparam int TCW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int AW       = $clog2(FIFO_DEPTH);
    localparam int LW       = AW + 1;
    localparam int GW       = RAMP_LOG2 + 1;
    localparam int PW       = WIDTH + GW + 1;
    localparam int TNW      = (TONE_DIV > 1) ? $clog2(TONE_DIV) : 1;
    localparam int DUC_DIV  = (FCLK / (FS_IN * RATE_INT) > 1) ? FCLK / (FS_IN * RATE_INT) : 1;
    localparam int DCW      = (DUC_DIV > 1) ? $clog2(DUC_DIV) : 1;
    localparam int YW       = WIDTH + IEXT;
    // FM step per unit sample: full-scale input deviates K Hz on a 32-bit phase at FS_IN.
    localparam logic [31:0] DEV  = 32'((64'(K) << (33 - WIDTH)) / 64'(FS_IN));
    localparam logic [31:0] CINC = 32'((64'(FC) << 32) / 64'(FCLK));
    localparam logic [GW-1:0] FULL = {1'b1, {RAMP_LOG2{1'b0}}};
    localparam logic signed [WIDTH-1:0] TONE_P = {2'b01, {(WIDTH-2){1'b0}}};
    localparam logic signed [WIDTH-1:0] TONE_N = {2'b11, {(WIDTH-2){1'b0}}};

    typedef enum logic [1:0] {IDLE = 2'd0, RAMP_UP = 2'd1, RUN = 2'd2, RAMP_DOWN = 2'd3} state_t;

    state_t             state_q, state_d;
    logic [GW-1:0]      gain_q, gain_d;
    logic [1:0]         mode_q;
    logic [TCW-1:0]     tcnt_q;
    logic               tick, active, push, pop, uflow;
    logic [WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]      rd_q, wr_q;
    logic [LW-1:0]      level_q;
    logic signed [WIDTH-1:0] src;
    logic signed [PW-1:0]    prod;
    logic [WIDTH-1:0]   samp;
    logic [TNW-1:0]     tone_cnt_q;
    logic               tone_neg_q;
    logic [WIDTH-1:0]   sample_q;
    logic               sample_stb_q, underrun_q;

    assign tick       = (tcnt_q == TCW'(TICK_DIV - 1));
    assign active     = tick && (state_q != IDLE);
    assign ready_in   = (level_q != LW'(FIFO_DEPTH));
    assign push       = valid_in && ready_in;
    assign pop        = active && (level_q != '0);
    assign uflow      = active && (state_q == RUN) && (level_q == '0);
    assign fifo_level = level_q;
    assign state_o    = state_q;
    assign sample_out = sample_q;
    assign sample_stb = sample_stb_q;
    assign underrun   = underrun_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) tcnt_q <= '0;
        else        tcnt_q <= tick ? '0 : tcnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= data_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            level_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop)  rd_q <= rd_q + 1'b1;
            level_q <= level_q + LW'(push) - LW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gain_q  <= '0;
            mode_q  <= '0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
            if (tick && state_q == IDLE && enable) mode_q <= mode;
        end
    end

    // Ramp direction follows enable on every tick, so reversals start from the current gain.
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        if (tick) begin
            if (state_q == IDLE) begin
                if (enable) state_d = RAMP_UP;
            end else if (enable) begin
                gain_d  = (gain_q == FULL) ? FULL : gain_q + 1'b1;
                state_d = (gain_d == FULL) ? RUN : RAMP_UP;
            end else begin
                gain_d  = (gain_q == '0) ? '0 : gain_q - 1'b1;
                state_d = (gain_d == '0) ? IDLE : RAMP_DOWN;
            end
        end
    end

    always_comb begin
        src = '0;
        case (mode_q)
            2'b00:   src = pop ? mem_q[rd_q] : '0;
            2'b10:   src = tone_neg_q ? TONE_N : TONE_P;
            default: src = '0;
        endcase
        prod = PW'(src) * PW'($signed({1'b0, gain_d}));
        samp = WIDTH'(prod >>> RAMP_LOG2);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tone_cnt_q   <= '0;
            tone_neg_q   <= 1'b0;
            sample_q     <= '0;
            sample_stb_q <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            sample_stb_q <= active;
            if (active) sample_q <= samp;
            if (uflow)  underrun_q <= 1'b1;
            if (tick && state_q == IDLE && enable) begin
                tone_cnt_q <= '0;
                tone_neg_q <= 1'b0;
            end else if (active && mode_q == 2'b10) begin
                if (tone_cnt_q == TNW'(TONE_DIV - 1)) begin
                    tone_cnt_q <= '0;
                    tone_neg_q <= ~tone_neg_q;
                end else begin
                    tone_cnt_q <= tone_cnt_q + 1'b1;
                end
            end
        end
    end

`ifdef TX_CHAIN_STATS_EN
    logic [15:0] ucnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          ucnt_q <= '0;
        else if (uflow && ucnt_q != 16'hFFFF) ucnt_q <= ucnt_q + 1'b1;
    end
    assign underrun_cnt = ucnt_q;
`else
    assign underrun_cnt = '0;
`endif

    // FM modulator: phase advances by sample*DEV; I output is a triangle cosine of the phase.
    logic [31:0]      fm_step, phase_q, phase_d;
    logic [WIDTH:0]   ip;
    logic [WIDTH-2:0] fold;
    logic [WIDTH-1:0] iq, data_int_q;
    logic             stb_int_q;

    always_comb begin
        fm_step = 32'($signed(sample_q)) * DEV;
        phase_d = phase_q + fm_step;
        ip      = phase_d[31 -: WIDTH+1] + {2'b01, {(WIDTH-1){1'b0}}};
        fold    = ip[WIDTH-1] ? ~ip[WIDTH-2:0] : ip[WIDTH-2:0];
        iq      = ip[WIDTH] ? -{1'b0, fold} : {1'b0, fold};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_q    <= '0;
            data_int_q <= '0;
            stb_int_q  <= 1'b0;
        end else begin
            stb_int_q <= sample_stb_q;
            if (sample_stb_q) begin
                phase_q    <= phase_d;
                data_int_q <= iq;
            end
        end
    end
    assign data_int = data_int_q;
    assign stb_int  = stb_int_q;

    // DUC: one-pole interpolator (pole 1-2^-IEXT, IEXT >= 1), square-wave carrier mix,
    // then a first-order 1-bit delta-sigma whose carry is the RF bit.
    logic [DCW-1:0]          dcnt_q;
    logic                    duc_stb, stb_out_q, rf_q;
    logic signed [YW-1:0]    y_q;
    logic signed [YW:0]      diff;
    logic signed [WIDTH-1:0] ytop, mix;
    logic [31:0]             carrier_q;
    logic [WIDTH-1:0]        ds_acc_q;
    logic [WIDTH:0]          ds_sum;

    assign duc_stb = (dcnt_q == DCW'(DUC_DIV - 1));

    always_comb begin
        diff   = $signed({data_int_q[WIDTH-1], data_int_q, {IEXT{1'b0}}}) - $signed({y_q[YW-1], y_q});
        ytop   = y_q[YW-1 -: WIDTH];
        mix    = carrier_q[31] ? -ytop : ytop;
        ds_sum = {1'b0, ds_acc_q} + {1'b0, ~mix[WIDTH-1], mix[WIDTH-2:0]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt_q    <= '0;
            y_q       <= '0;
            carrier_q <= '0;
            ds_acc_q  <= '0;
            rf_q      <= 1'b0;
            stb_out_q <= 1'b0;
        end else begin
            dcnt_q    <= duc_stb ? '0 : dcnt_q + 1'b1;
            stb_out_q <= duc_stb;
            if (duc_stb) begin
                y_q       <= y_q + YW'(diff >>> IEXT);
                carrier_q <= carrier_q + CINC;
                ds_acc_q  <= ds_sum[WIDTH-1:0];
                rf_q      <= ds_sum[WIDTH];
            end
        end
    end
    assign stb_out = stb_out_q;
    assign rf_out  = rf_q && (state_q != IDLE);
endmodule

// File: doc/tx_chain.md
TX_CHAIN -- requirements
Module: tx_chain

Interface
REQ-001 SHALL have parameter WIDTH, default 16, sample width in bits.
REQ-002 SHALL have parameters FCLK, FS_IN, RATE_INT, FC, K and IEXT, defaults 200000000, 48000, 100, 99000000, 200000 and 7, passed to the FM/DUC chain.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, input buffer depth; power of two, at least 2.
REQ-004 SHALL have parameter RAMP_LOG2, default 8; full-scale gain = 2^RAMP_LOG2.
REQ-005 SHALL have parameter TONE_DIV, default 24, sample ticks per test-tone half-period.
REQ-006 Ports SHALL be, in order:
- clk, input, 1 bit: clock.
- rst_n, input, 1 bit: reset, asynchronous, active-low.
- data_in, input, WIDTH bits: signed audio sample.
- valid_in, input, 1 bit: data_in is valid.
- ready_in, output, 1 bit: buffer can accept a sample.
- enable, input, 1 bit: transmit request.
- mode, input, 2 bits: 00 FM audio, 01 unmodulated carrier, 10 test tone, 11 treated as 01.
- sample_out, output, WIDTH bits: gained sample sent to the modulator.
- sample_stb, output, 1 bit: sample_out is valid.
- data_int, output, WIDTH bits: modulator I output.
- stb_int, output, 1 bit: data_int is valid.
- rf_out, output, 1 bit: 1-bit delta-sigma RF output.
- stb_out, output, 1 bit: upconverter output strobe.
- state_o, output, 2 bits: current state.
- underrun, output, 1 bit: sticky underrun flag.
- fifo_level, output, log2(FIFO_DEPTH)+1 bits: buffer occupancy.
- underrun_cnt, output, 16 bits: underrun count.

Function
REQ-007 SHALL accept a sample on any cycle with valid_in and ready_in both high; ready_in = (fifo_level < FIFO_DEPTH).
REQ-008 SHALL generate a one-cycle tick every FCLK/FS_IN cycles (integer division); the first tick occurs FCLK/FS_IN cycles after reset release.
REQ-009 SHALL implement states IDLE=0, RAMP_UP=1, RUN=2 and RAMP_DOWN=3, evaluated on ticks only.
REQ-010 SHALL make these transitions:
- IDLE to RAMP_UP on enable=1, latching mode.
- RAMP_UP: gain+1 per tick; to RUN when gain reaches 2^RAMP_LOG2.
- RUN to RAMP_DOWN on enable=0.
- RAMP_DOWN: gain-1 per tick; to IDLE when gain reaches 0.
- enable=0 in RAMP_UP goes to RAMP_DOWN from the current gain.
- enable=1 in RAMP_DOWN goes to RAMP_UP from the current gain.
REQ-011 SHALL, on each tick outside IDLE, pop one FIFO entry when non-empty; when empty, it SHALL use 0 and, in RUN only, set underrun and increment underrun_cnt, saturating at 0xFFFF.
REQ-012 SHALL, in IDLE, neither pop nor discard FIFO contents.
REQ-013 SHALL select the source sample from the mode latched at IDLE exit; mode changes outside IDLE SHALL be ignored.
REQ-014 The source sample SHALL be the popped sample in mode 00, 0 in modes 01 and 11, and +/-2^(WIDTH-2) toggling every TONE_DIV ticks in mode 10, starting positive.
REQ-015 SHALL compute sample_out = (source x gain) >>> RAMP_LOG2, signed, with a full-width product and result truncated to WIDTH bits.
REQ-016 sample_stb SHALL pulse exactly one cycle after each tick when not in IDLE.
REQ-017 sample_out/sample_stb SHALL drive the FM modulator input at FS_IN, which feeds the DUC at FS_IN*RATE_INT and then the 1-bit delta-sigma stage, with data_int/stb_int taken from the modulator I output.
REQ-018 SHALL hold rf_out=0 while state_o=IDLE; stb_out SHALL pass the DUC strobe unmodified.
REQ-019 A simultaneous push and pop SHALL leave fifo_level unchanged; a push when full SHALL be impossible because ready_in=0.

Reset
REQ-020 SHALL, on rst_n low, asynchronously set state IDLE, gain 0, FIFO empty (fifo_level=0, ready_in=1), tick counter 0, tone phase positive, and sample_out, sample_stb, rf_out, underrun and underrun_cnt to 0.
REQ-021 Reset mid-operation SHALL discard buffered samples, and the first tick after release SHALL follow REQ-008.

Configuration
REQ-022 With macro TX_CHAIN_STATS_EN defined, underrun_cnt SHALL count per REQ-011.
REQ-023 Without TX_CHAIN_STATS_EN, underrun_cnt SHALL be constant 0, and the underrun flag SHALL still operate.

Verification
(Parameters for these scenarios: FCLK=4800, FS_IN=48, RAMP_LOG2=2, FIFO_DEPTH=4.)
REQ-024 Push 4 samples with enable=0 -> ready_in=0, fifo_level=4, no pops, rf_out=0.
REQ-025 enable=1, mode=00, with constant 0x4000 supplied -> sample_out = 0x1000, 0x2000, 0x3000, 0x4000 on successive ticks 100 cycles apart, then state_o=2.
REQ-026 In RUN with the FIFO drained and 3 empty ticks -> sample_out=0, underrun=1, underrun_cnt=3 with TX_CHAIN_STATS_EN defined, 0 without.
REQ-027 enable=0 at gain 2 during RAMP_UP -> gain 1 then 0, state_o goes 3 then 0, and rf_out is held at 0.
REQ-028 mode=10, TONE_DIV=2, in RUN -> sample_out = +0x4000, +0x4000, -0x4000, -0x4000 repeating; a mode change while in RUN is ignored.
REQ-029 rst_n pulsed low mid-RUN with fifo_level=3 -> all outputs are 0 immediately (fifo_level=0, ready_in=1), and the first tick comes 100 cycles after release.
